// File: rtl/uart_frame_receiver_pkg.sv
// Shared types and defaults for the UART frame receiver and its bit-level deserialiser.
package uart_frame_receiver_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 87;
    localparam logic [7:0]  DEF_SYNC_BYTE    = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_HOLD
    } frame_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_frame_receiver_if.sv
// Frame output bus: valid/ready handshake plus frame status towards the cipher datapath.
interface uart_frame_receiver_if #(
    parameter int unsigned NUM_BYTES = 16
);
    localparam int unsigned DW = 8 * NUM_BYTES;
    localparam int unsigned CW = $clog2(NUM_BYTES + 1);

    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] byte_cnt;
    logic          busy;
    logic          err_timeout;
    logic          err_overrun;

    modport master (
        input  out_ready,
        output out_valid, out_data, byte_cnt, busy, err_timeout, err_overrun
    );

    modport slave (
        output out_ready,
        input  out_valid, out_data, byte_cnt, busy, err_timeout, err_overrun
    );
endinterface

// File: rtl/uart_frame_receiver_rx.sv
// 8N1 UART deserialiser: emits a one-cycle byte_valid strobe with byte_data at mid stop bit.
module uart_frame_receiver_rx
    import uart_frame_receiver_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data
);
    localparam int unsigned    BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BIT_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  BIT_MID  = BW'((CLKS_PER_BIT - 1) / 2);

    rx_state_t     state_q, state_n;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic [BW-1:0] tick_q, tick_n;
    logic [2:0]    idx_q, idx_n;
    logic [7:0]    shreg_q, shreg_n;
    logic [7:0]    data_q, data_n;
    logic          valid_q, valid_n;

    assign rx_s       = sync_q[1];
    assign byte_valid = valid_q;
    assign byte_data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            sync_q  <= 2'b11;
            tick_q  <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            sync_q  <= {sync_q[0], rx};
            tick_q  <= tick_n;
            idx_q   <= idx_n;
            shreg_q <= shreg_n;
            data_q  <= data_n;
            valid_q <= valid_n;
        end
    end

    // Start bit is re-checked at its midpoint; data and stop bits are sampled one bit period apart.
    always_comb begin
        state_n = state_q;
        tick_n  = tick_q;
        idx_n   = idx_q;
        shreg_n = shreg_q;
        data_n  = data_q;
        valid_n = 1'b0;
        case (state_q)
            RX_IDLE: begin
                tick_n = '0;
                if (!rx_s) state_n = RX_START;
            end
            RX_START: begin
                if (tick_q == BIT_MID) begin
                    tick_n  = '0;
                    idx_n   = '0;
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    tick_n = tick_q + BW'(1);
                end
            end
            RX_DATA: begin
                if (tick_q == BIT_LAST) begin
                    tick_n  = '0;
                    shreg_n = {rx_s, shreg_q[7:1]};
                    idx_n   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_n = RX_STOP;
                end else begin
                    tick_n = tick_q + BW'(1);
                end
            end
            RX_STOP: begin
                if (tick_q == BIT_LAST) begin
                    tick_n  = '0;
                    state_n = RX_IDLE;
                    if (rx_s) begin
                        valid_n = 1'b1;
                        data_n  = shreg_q;
                    end
                end else begin
                    tick_n = tick_q + BW'(1);
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_frame_receiver.sv
// Packs NUM_BYTES UART bytes into one wide frame with optional sync header,
// inter-byte timeout and a valid/ready output handshake.
module uart_frame_receiver
    import uart_frame_receiver_pkg::*;
#(
    parameter int unsigned NUM_BYTES    = 16,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit          SYNC_EN      = 1'b1,
    parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYC  = 1000000,
    parameter bit          MSB_FIRST    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    uart_frame_receiver_if.master bus
);
    localparam int unsigned DW = 8 * NUM_BYTES;
    localparam int unsigned CW = $clog2(NUM_BYTES + 1);
    localparam int unsigned TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic          strobe;
    logic [7:0]    rx_byte;

    frame_state_t  state_q, state_n;
    logic [DW-1:0] data_q, data_n, shifted;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [TW-1:0] tmo_q, tmo_n;
    logic          valid_q, valid_n;
    logic          busy_q, busy_n;
    logic          err_t_q, err_t_n;
    logic          err_o_q, err_o_n;
    logic          idle_take;

    uart_frame_receiver_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(strobe),
        .byte_data (rx_byte)
    );

    assign bus.out_valid   = valid_q;
    assign bus.out_data    = data_q;
    assign bus.byte_cnt    = cnt_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_t_q;
    assign bus.err_overrun = err_o_q;

    // Shift-in keeps the first received byte at the chosen end once the frame is complete.
    always_comb begin
        shifted = MSB_FIRST ? ((data_q << 8) | DW'(rx_byte))
                            : ((data_q >> 8) | (DW'(rx_byte) << (DW - 8)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_t_q <= 1'b0;
            err_o_q <= 1'b0;
        end else begin
            state_q <= state_n;
            data_q  <= data_n;
            cnt_q   <= cnt_n;
            tmo_q   <= tmo_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            err_t_q <= err_t_n;
            err_o_q <= err_o_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        data_n    = data_q;
        cnt_n     = cnt_q;
        tmo_n     = tmo_q;
        valid_n   = valid_q;
        err_t_n   = 1'b0;
        err_o_n   = 1'b0;
        idle_take = 1'b0;
        case (state_q)
            ST_IDLE: idle_take = strobe;
            ST_COLLECT: begin
                if (strobe) begin
                    data_n = shifted;
                    cnt_n  = cnt_q + CW'(1);
                    tmo_n  = '0;
                    if (cnt_q == CW'(NUM_BYTES - 1)) begin
                        state_n = ST_HOLD;
                        valid_n = 1'b1;
                    end
                end else if (TIMEOUT_CYC != 0) begin
                    if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                        err_t_n = 1'b1;
                        cnt_n   = '0;
                        data_n  = '0;
                        tmo_n   = '0;
                        state_n = ST_IDLE;
                    end else begin
                        tmo_n = tmo_q + TW'(1);
                    end
                end
            end
            ST_HOLD: begin
                // A byte arriving on the release edge starts the next frame instead of overrunning.
                if (bus.out_ready) begin
                    valid_n   = 1'b0;
                    cnt_n     = '0;
                    state_n   = ST_IDLE;
                    idle_take = strobe;
                end else if (strobe) begin
                    err_o_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (idle_take) begin
            tmo_n = '0;
            if (SYNC_EN) begin
                if (rx_byte == SYNC_BYTE) state_n = ST_COLLECT;
            end else begin
                data_n = shifted;
                cnt_n  = CW'(1);
                if (NUM_BYTES == 1) begin
                    state_n = ST_HOLD;
                    valid_n = 1'b1;
                end else begin
                    state_n = ST_COLLECT;
                end
            end
        end

        busy_n = (state_n == ST_COLLECT) || ((state_n != ST_IDLE) && !valid_n);
    end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Scoreboard bench: three receiver configurations, each with its own serial line and output monitor.
module tb_uart_frame_receiver;

    localparam int unsigned BIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, last_strb = 0, k;
    int   tmo_cnt[3], ovr_cnt[3];
    bit   pv[3];
    logic [31:0] exp_a[$], exp_b[$], exp_c[$];

    uart_frame_receiver_if #(.NUM_BYTES(4)) bus_a ();
    uart_frame_receiver_if #(.NUM_BYTES(4)) bus_b ();
    uart_frame_receiver_if #(.NUM_BYTES(4)) bus_c ();

    uart_frame_receiver #(.NUM_BYTES(4), .CLKS_PER_BIT(BIT), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5),
                          .TIMEOUT_CYC(2000), .MSB_FIRST(1'b1))
        dut_a (.clk(clk), .rst(rst), .rx(rx_a), .bus(bus_a));
    uart_frame_receiver #(.NUM_BYTES(4), .CLKS_PER_BIT(BIT), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5),
                          .TIMEOUT_CYC(2000), .MSB_FIRST(1'b0))
        dut_b (.clk(clk), .rst(rst), .rx(rx_b), .bus(bus_b));
    uart_frame_receiver #(.NUM_BYTES(4), .CLKS_PER_BIT(BIT), .SYNC_EN(1'b0), .SYNC_BYTE(8'hA5),
                          .TIMEOUT_CYC(0), .MSB_FIRST(1'b1))
        dut_c (.clk(clk), .rst(rst), .rx(rx_c), .bus(bus_c));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic expect_frame(input int id, input logic [31:0] v);
        case (id)
            0:       exp_a.push_back(v);
            1:       exp_b.push_back(v);
            default: exp_c.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int id, output bit have, output logic [31:0] v);
        have = 1'b0;
        v    = '0;
        case (id)
            0:       if (exp_a.size() > 0) begin have = 1'b1; v = exp_a.pop_front(); end
            1:       if (exp_b.size() > 0) begin have = 1'b1; v = exp_b.pop_front(); end
            default: if (exp_c.size() > 0) begin have = 1'b1; v = exp_c.pop_front(); end
        endcase
    endtask

    // Frame is compared on the first cycle out_valid is seen; error pulses are tallied per cycle.
    task automatic mon_step(input int id, input logic v, input logic [31:0] d, input logic [2:0] c,
                            input logic et, input logic eo);
        bit          have;
        logic [31:0] e;
        if (et) tmo_cnt[id]++;
        if (eo) ovr_cnt[id]++;
        if (v && !pv[id]) begin
            pop_exp(id, have, e);
            if (!have) begin
                n_tests++;
                n_fail++;
                $display("FAIL frame_unexpected[%0d]: got %h, expected no frame", id, d);
            end else begin
                check($sformatf("frame_data[%0d]", id), d, e);
                check($sformatf("frame_cnt[%0d]", id), 32'(c), 32'd4);
            end
        end
        pv[id] = v;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            pv[0] = 1'b0; pv[1] = 1'b0; pv[2] = 1'b0;
        end else begin
            if (bus_a.out_valid && !pv[0]) check("latency_a", 32'(cyc - last_strb), 32'd1);
            mon_step(0, bus_a.out_valid, bus_a.out_data, bus_a.byte_cnt, bus_a.err_timeout, bus_a.err_overrun);
            mon_step(1, bus_b.out_valid, bus_b.out_data, bus_b.byte_cnt, bus_b.err_timeout, bus_b.err_overrun);
            mon_step(2, bus_c.out_valid, bus_c.out_data, bus_c.byte_cnt, bus_c.err_timeout, bus_c.err_overrun);
            if (dut_a.strobe) last_strb = cyc;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int id, input logic v);
        case (id)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic send_byte(input int id, input logic [7:0] b);
        set_rx(id, 1'b0);
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            set_rx(id, b[i]);
            wait_clks(BIT);
        end
        set_rx(id, 1'b1);
        wait_clks(BIT + 3);
    endtask

    task automatic check_idle(input string name, input logic v, input logic [2:0] c, input logic b,
                              input logic et, input logic eo, input logic [31:0] d);
        check({name, "_flags"}, 32'({v, b, et, eo, c}), 32'd0);
        check({name, "_data"}, d, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b0;
        bus_c.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin tmo_cnt[i] = 0; ovr_cnt[i] = 0; pv[i] = 1'b0; end
        wait_clks(5);
        rst = 1'b0;
        check_idle("reset_a", bus_a.out_valid, bus_a.byte_cnt, bus_a.busy, bus_a.err_timeout, bus_a.err_overrun, bus_a.out_data);
        check_idle("reset_b", bus_b.out_valid, bus_b.byte_cnt, bus_b.busy, bus_b.err_timeout, bus_b.err_overrun, bus_b.out_data);
        check_idle("reset_c", bus_c.out_valid, bus_c.byte_cnt, bus_c.busy, bus_c.err_timeout, bus_c.err_overrun, bus_c.out_data);

        // Basic MSB-first frame, consumer always ready
        expect_frame(0, 32'h11223344);
        send_byte(0, 8'hA5); send_byte(0, 8'h11); send_byte(0, 8'h22);
        check("busy_mid_a", 32'(bus_a.busy), 32'd1);
        send_byte(0, 8'h33); send_byte(0, 8'h44);
        wait_clks(4);
        check("released_a", 32'({bus_a.out_valid, bus_a.busy, bus_a.byte_cnt}), 32'd0);

        // LSB-first frame held under back-pressure
        expect_frame(1, 32'h44332211);
        send_byte(1, 8'hA5); send_byte(1, 8'h11); send_byte(1, 8'h22); send_byte(1, 8'h33); send_byte(1, 8'h44);
        wait_clks(100);
        check("hold_valid_b", 32'(bus_b.out_valid), 32'd1);
        check("hold_data_b", bus_b.out_data, 32'h44332211);
        check("hold_cnt_b", 32'(bus_b.byte_cnt), 32'd4);
        bus_b.out_ready = 1'b1;
        wait_clks(1);
        check("handshake_b", 32'({bus_b.out_valid, bus_b.byte_cnt}), 32'd0);

        // Non-sync bytes ahead of the header are dropped silently
        expect_frame(0, 32'h55667788);
        send_byte(0, 8'h00); send_byte(0, 8'h5A);
        check("pre_sync_idle_a", 32'({bus_a.busy, bus_a.byte_cnt}), 32'd0);
        send_byte(0, 8'hA5); send_byte(0, 8'h55); send_byte(0, 8'h66); send_byte(0, 8'h77); send_byte(0, 8'h88);
        wait_clks(4);
        check("no_err_a", 32'(tmo_cnt[0] + ovr_cnt[0]), 32'd0);

        // Inter-byte timeout discards the partial frame
        send_byte(0, 8'hA5); send_byte(0, 8'h11); send_byte(0, 8'h22);
        check("partial_cnt_a", 32'(bus_a.byte_cnt), 32'd2);
        wait_clks(2500);
        check("timeout_pulses_a", 32'(tmo_cnt[0]), 32'd1);
        check_idle("after_timeout_a", bus_a.out_valid, bus_a.byte_cnt, bus_a.busy, bus_a.err_timeout, bus_a.err_overrun, bus_a.out_data);
        expect_frame(0, 32'hDEADBEEF);
        send_byte(0, 8'hA5); send_byte(0, 8'hDE); send_byte(0, 8'hAD); send_byte(0, 8'hBE); send_byte(0, 8'hEF);

        // Overrun while held, then a byte coinciding with the release becomes byte 0
        expect_frame(2, 32'h01020304);
        send_byte(2, 8'h01); send_byte(2, 8'h02); send_byte(2, 8'h03); send_byte(2, 8'h04);
        send_byte(2, 8'h77);
        check("overrun_pulses_c", 32'(ovr_cnt[2]), 32'd1);
        check("overrun_data_c", bus_c.out_data, 32'h01020304);
        check("overrun_valid_c", 32'(bus_c.out_valid), 32'd1);
        expect_frame(2, 32'h10203040);
        fork
            send_byte(2, 8'h10);
            begin
                k = 0;
                while (!dut_c.strobe && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                if (k >= 200) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL strobe_wait_c: got no byte strobe in 200 cycles, expected one");
                end
                bus_c.out_ready = 1'b1;
                @(negedge clk);
                check("release_byte0_c", 32'({bus_c.out_valid, bus_c.byte_cnt}), 32'd1);
            end
        join
        send_byte(2, 8'h20); send_byte(2, 8'h30); send_byte(2, 8'h40);

        // Reset mid-frame discards partial data
        send_byte(0, 8'hA5); send_byte(0, 8'h01); send_byte(0, 8'h02);
        check("pre_reset_a", 32'({bus_a.busy, bus_a.byte_cnt}), 32'({1'b1, 3'd2}));
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        check_idle("mid_reset_a", bus_a.out_valid, bus_a.byte_cnt, bus_a.busy, bus_a.err_timeout, bus_a.err_overrun, bus_a.out_data);
        expect_frame(0, 32'hAABBCCDD);
        send_byte(0, 8'hA5); send_byte(0, 8'hAA); send_byte(0, 8'hBB); send_byte(0, 8'hCC); send_byte(0, 8'hDD);

        wait_clks(20);
        check("pending_a", 32'(exp_a.size()), 32'd0);
        check("pending_b", 32'(exp_b.size()), 32'd0);
        check("pending_c", 32'(exp_c.size()), 32'd0);
        check("tmo_total_a", 32'(tmo_cnt[0]), 32'd1);
        check("ovr_total_a", 32'(ovr_cnt[0]), 32'd0);
        check("err_total_b", 32'(tmo_cnt[1] + ovr_cnt[1]), 32'd0);
        check("tmo_total_c", 32'(tmo_cnt[2]), 32'd0);
        check("ovr_total_c", 32'(ovr_cnt[2]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
